// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - MDop encodings driven by decode
//   - default MULT/DIV busy latencies
//   - counter width helper: enough bits to hold max(MULT_LAT, DIV_LAT)
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int unsigned MD_MULT_LAT = 5;
    localparam int unsigned MD_DIV_LAT  = 10;

    // $clog2(max(mult_lat, div_lat) + 1)
    function automatic int unsigned md_cnt_width(input int unsigned mult_lat,
                                                 input int unsigned div_lat);
        int unsigned max_lat;
        max_lat = (mult_lat > div_lat) ? mult_lat : div_lat;
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/md_div32.sv
// md_div32: combinational 32-bit divider, signed or unsigned.
// Ports:
//   signed_i    1  treat operands as two's complement (DIV) instead of unsigned (DIVU)
//   dividend_i 32  rs operand
//   divisor_i  32  rt operand
//   quot_o     32  quotient, truncated toward zero
//   rem_o      32  remainder, sign follows the dividend
//   div_zero_o  1  divisor is zero; quot_o/rem_o are meaningless
module md_div32 (
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o,
    output logic        div_zero_o
);

    logic        neg_n;
    logic        neg_d;
    logic [31:0] abs_n;
    logic [31:0] abs_d;
    logic [31:0] safe_d;
    logic [31:0] uq;
    logic [31:0] ur;

    always_comb begin
        div_zero_o = (divisor_i == 32'd0);
        neg_n      = signed_i & dividend_i[31];
        neg_d      = signed_i & divisor_i[31];
        abs_n      = neg_n ? (~dividend_i + 32'd1) : dividend_i;
        abs_d      = neg_d ? (~divisor_i + 32'd1) : divisor_i;
        // Keep the divider well defined on a zero divisor; the result is discarded anyway.
        safe_d     = div_zero_o ? 32'd1 : abs_d;
        uq         = abs_n / safe_d;
        ur         = abs_n % safe_d;
        // 0x80000000 / -1: |n| = 0x80000000 as unsigned, quotient negates back to
        // 0x80000000 and the remainder is 0, which is the defined overflow result.
        quot_o     = (neg_n ^ neg_d) ? (~uq + 32'd1) : uq;
        rem_o      = neg_n ? (~ur + 32'd1) : ur;
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Ports:
//   clk    1   rising-edge clock
//   reset  1   synchronous active-low reset
//   Start  1   one-cycle request qualified by MDop
//   MDop   3   MULT/MULTU/DIV/DIVU/MTHI/MTLO, 6/7 no-op
//   D1    32   rs operand (dividend / multiplicand / MTHI-MTLO data)
//   D2    32   rt operand (divisor / multiplier)
//   Busy   1   registered, high while an operation is in flight
//   HI    32   architectural HI
//   LO    32   architectural LO
// The result is computed at the Start edge and parked in pending registers; the
// busy counter only models latency, and HI/LO are committed when it reaches zero.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_LAT = MD_MULT_LAT,
    parameter int unsigned DIV_LAT  = MD_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDop,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CntW = md_cnt_width(MULT_LAT, DIV_LAT);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;
    logic            pend_wr_q, pend_wr_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        div_zero;

    assign prod_s = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
    assign prod_u = {32'd0, D1} * {32'd0, D2};

    md_div32 u_div (
        .signed_i   (MDop == MD_DIV),
        .dividend_i (D1),
        .divisor_i  (D2),
        .quot_o     (div_quot),
        .rem_o      (div_rem),
        .div_zero_o (div_zero)
    );

    always_comb begin
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        if (busy_q) begin
            // Start during RUN is ignored, MTHI/MTLO included.
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else if (Start) begin
            case (MDop)
                MD_MULT, MD_MULTU: begin
                    {pend_hi_d, pend_lo_d} = (MDop == MD_MULT) ? prod_s : prod_u;
                    pend_wr_d = 1'b1;
                    cnt_d     = CntW'(MULT_LAT);
                    busy_d    = 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    pend_hi_d = div_rem;
                    pend_lo_d = div_quot;
                    // Divide by zero still burns the full latency but commits nothing.
                    pend_wr_d = ~div_zero;
                    cnt_d     = CntW'(DIV_LAT);
                    busy_d    = 1'b1;
                end
                MD_MTHI: hi_d = D1;
                MD_MTLO: lo_d = D1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit. A cycle driver applies inputs on the
// falling edge, steps a behavioural model of the architectural HI/LO/Busy and pushes
// the outputs expected after the next rising edge; a monitor pops and compares them.
module tb_md_unit;

    localparam int MultLat = 5;
    localparam int DivLat  = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDop;
    logic [31:0] D1;
    logic [31:0] D2;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    md_unit #(
        .MULT_LAT (MultLat),
        .DIV_LAT  (DivLat)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDop  (MDop),
        .D1    (D1),
        .D2    (D2),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cycle = 0;

    // Behavioural model state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_rem = 0;
    logic [31:0] m_res_hi = 32'd0;
    logic [31:0] m_res_lo = 32'd0;
    logic        m_res_ok = 1'b0;

    task automatic model_step(input logic rst, input logic st, input logic [2:0] op,
                              input logic [31:0] d1, input logic [31:0] d2);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        exp_t            e;
        sa = longint'($signed(d1));
        sb = longint'($signed(d2));
        ua = {32'd0, d1};
        ub = {32'd0, d2};
        if (!rst) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_rem = 0;
            m_res_ok = 1'b0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0 && m_res_ok) begin
                m_hi = m_res_hi;
                m_lo = m_res_lo;
            end
        end else if (st) begin
            case (op)
                3'd0: begin
                    sq = sa * sb;
                    {m_res_hi, m_res_lo} = sq;
                    m_res_ok = 1'b1;
                    m_rem = MultLat;
                end
                3'd1: begin
                    up = ua * ub;
                    {m_res_hi, m_res_lo} = up;
                    m_res_ok = 1'b1;
                    m_rem = MultLat;
                end
                3'd2: begin
                    m_res_ok = (d2 != 32'd0);
                    if (m_res_ok) begin
                        sq = sa / sb;
                        sr = sa % sb;
                        m_res_lo = 32'(sq);
                        m_res_hi = 32'(sr);
                    end
                    m_rem = DivLat;
                end
                3'd3: begin
                    m_res_ok = (d2 != 32'd0);
                    if (m_res_ok) begin
                        m_res_lo = d1 / d2;
                        m_res_hi = d1 % d2;
                    end
                    m_rem = DivLat;
                end
                3'd4: m_hi = d1;
                3'd5: m_lo = d1;
                default: ;
            endcase
        end
        e.busy = (m_rem != 0);
        e.hi   = m_hi;
        e.lo   = m_lo;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic rst, input logic st, input logic [2:0] op,
                       input logic [31:0] d1, input logic [31:0] d2);
        @(negedge clk);
        reset = rst;
        Start = st;
        MDop  = op;
        D1    = d1;
        D2    = d2;
        model_step(rst, st, op, d1, d2);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2);
        cyc(1'b1, 1'b1, op, d1, d2);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 3'($urandom_range(7)), $urandom, $urandom);
    endtask

    task automatic run_idle();
        for (int i = 0; i < 20 && m_rem != 0; i++) idle();
    endtask

    // Direct check against literal values, taken after the last modelled edge.
    task automatic check_regs(input string name, input logic [31:0] hi, input logic [31:0] lo);
        @(posedge clk);
        #2;
        n_tests++;
        if (HI !== hi || LO !== lo) begin
            n_fail++;
            $display("FAIL %s: HI/LO got %h/%h expected %h/%h", name, HI, LO, hi, lo);
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            n_cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (Busy !== e.busy || HI !== e.hi || LO !== e.lo) begin
                    n_fail++;
                    $display("FAIL sb cycle %0d: Busy/HI/LO got %0b/%h/%h expected %0b/%h/%h",
                             n_cycle, Busy, HI, LO, e.busy, e.hi, e.lo);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Driver
    initial begin
        logic        r_rst;
        logic        r_st;
        logic [2:0]  r_op;
        reset = 1'b0;
        Start = 1'b0;
        MDop  = 3'd0;
        D1    = 32'd0;
        D2    = 32'd0;
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check_regs("reset", 32'd0, 32'd0);

        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        run_idle();
        check_regs("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        run_idle();
        check_regs("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_idle();
        check_regs("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'd3, 32'd7, 32'd2);
        run_idle();
        check_regs("divu", 32'd1, 32'd3);

        issue(3'd4, 32'h1234, 32'd0);
        issue(3'd5, 32'h5678, 32'd0);
        issue(3'd3, 32'd99, 32'd0);
        run_idle();
        check_regs("divu_zero", 32'h1234, 32'h5678);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_idle();
        check_regs("div_ovf", 32'd0, 32'h8000_0000);

        issue(3'd4, 32'hAAAA_0000, 32'd0);
        check_regs("mthi", 32'hAAAA_0000, 32'h8000_0000);

        issue(3'd6, 32'h1111_1111, 32'd5);
        check_regs("reserved", 32'hAAAA_0000, 32'h8000_0000);

        // MTLO during RUN ignored, then a MULT at the Busy fall edge
        issue(3'd0, 32'd7, 32'd9);
        idle();
        issue(3'd5, 32'hDEAD_BEEF, 32'd0);
        run_idle();
        issue(3'd0, 32'h0001_0000, 32'h0001_0000);
        run_idle();
        check_regs("b2b_mult", 32'd1, 32'd0);

        // Reset on the 4th Busy cycle of a DIV
        issue(3'd3, 32'd100, 32'd7);
        idle();
        idle();
        idle();
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < 12; i++) idle();
        check_regs("reset_mid_div", 32'd0, 32'd0);

        for (int i = 0; i < 800; i++) begin
            r_rst = ($urandom_range(99) != 0);
            r_st  = ($urandom_range(1) == 1);
            r_op  = 3'($urandom_range(7));
            cyc(r_rst, r_st, r_op, rand_word(), rand_word());
        end
        run_idle();
        idle();
        idle();
        @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
